// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles every request, response and bus signal of the fetch/data memory
//   arbiter. Clock and reset stay outside as plain ports.
//
//   master : the arbiter side (drives arb_o_* and bus_o_*)
//   slave  : the environment side (fetch stage, memory stage and memory bus)
//
//   Fetch request   : fetch_i_req, fetch_i_addr
//   Data request    : memory_i_req, memory_i_we, memory_i_addr,
//                     memory_i_wdata, memory_i_wstrb
//   Responses       : arb_o_fetch_rdata/done, arb_o_mem_rdata/done
//   Stalls          : arb_o_fetch_stall, arb_o_mem_stall
//   Memory bus      : bus_o_valid/we/addr/wdata/wstrb, bus_i_ready, bus_i_rdata
//   Error reporting : arb_o_bus_err, arb_o_err_addr
interface mem_bus_arbiter_if;
    logic        fetch_i_req;
    logic [31:0] fetch_i_addr;
    logic        memory_i_req;
    logic        memory_i_we;
    logic [31:0] memory_i_addr;
    logic [31:0] memory_i_wdata;
    logic [3:0]  memory_i_wstrb;

    logic [31:0] arb_o_fetch_rdata;
    logic        arb_o_fetch_done;
    logic [31:0] arb_o_mem_rdata;
    logic        arb_o_mem_done;
    logic        arb_o_fetch_stall;
    logic        arb_o_mem_stall;

    logic        bus_o_valid;
    logic        bus_o_we;
    logic [31:0] bus_o_addr;
    logic [31:0] bus_o_wdata;
    logic [3:0]  bus_o_wstrb;
    logic        bus_i_ready;
    logic [31:0] bus_i_rdata;

    logic        arb_o_bus_err;
    logic [31:0] arb_o_err_addr;

    modport master (
        input  fetch_i_req, fetch_i_addr,
        input  memory_i_req, memory_i_we, memory_i_addr, memory_i_wdata, memory_i_wstrb,
        output arb_o_fetch_rdata, arb_o_fetch_done, arb_o_mem_rdata, arb_o_mem_done,
        output arb_o_fetch_stall, arb_o_mem_stall,
        output bus_o_valid, bus_o_we, bus_o_addr, bus_o_wdata, bus_o_wstrb,
        input  bus_i_ready, bus_i_rdata,
        output arb_o_bus_err, arb_o_err_addr
    );

    modport slave (
        output fetch_i_req, fetch_i_addr,
        output memory_i_req, memory_i_we, memory_i_addr, memory_i_wdata, memory_i_wstrb,
        input  arb_o_fetch_rdata, arb_o_fetch_done, arb_o_mem_rdata, arb_o_mem_done,
        input  arb_o_fetch_stall, arb_o_mem_stall,
        input  bus_o_valid, bus_o_we, bus_o_addr, bus_o_wdata, bus_o_wstrb,
        output bus_i_ready, bus_i_rdata,
        input  arb_o_bus_err, arb_o_err_addr
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between instruction fetch and the load/store stage.
//   A winning request is latched onto a valid/ready bus; the response comes
//   back as a one-cycle done pulse to the owner. Includes a starvation guard
//   for fetch and a bus-timeout watchdog.
//
//   Ports
//     clk     : clock, rising edge
//     rst     : asynchronous reset, active low
//     arbBus  : mem_bus_arbiter_if.master (requests, responses, stalls, bus,
//               error reporting)
//
//   state | meaning
//   IDLE  | sample requests, grant one and latch it onto the bus
//   REQ   | bus_o_valid high, waiting for ready or watchdog expiry
//   RESP  | owner's done pulse; no grant, always back to IDLE
module mem_bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master arbBus
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} arbStateT;

    localparam logic [2:0] STREAK_MAX = 3'(MAX_D_STREAK);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    arbStateT    state;
    logic [2:0]  streak;
    logic [7:0]  waitCnt;
    logic        ownerData;

    logic        busValid;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busWstrb;

    logic [31:0] fetchRdata;
    logic        fetchDone;
    logic [31:0] memRdata;
    logic        memDone;
    logic        busErr;
    logic [31:0] errAddr;

    logic        dataWins;
    logic        timedOut;
    logic [31:0] respData;

    assign dataWins = arbBus.memory_i_req &
                      ((streak < STREAK_MAX) | ~arbBus.fetch_i_req);
    assign timedOut = ~arbBus.bus_i_ready & (waitCnt == WAIT_LAST);
    // An aborted transfer returns zero rather than whatever is on the bus.
    assign respData = arbBus.bus_i_ready ? arbBus.bus_i_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            streak     <= 3'd0;
            waitCnt    <= 8'd0;
            ownerData  <= 1'b0;
            busValid   <= 1'b0;
            busWe      <= 1'b0;
            busAddr    <= 32'd0;
            busWdata   <= 32'd0;
            busWstrb   <= 4'd0;
            fetchRdata <= 32'd0;
            fetchDone  <= 1'b0;
            memRdata   <= 32'd0;
            memDone    <= 1'b0;
            busErr     <= 1'b0;
            errAddr    <= 32'd0;
        end else begin
            // Pulses last one cycle unless re-armed below.
            fetchDone <= 1'b0;
            memDone   <= 1'b0;
            busErr    <= 1'b0;

            case (state)
                IDLE: begin
                    if (dataWins) begin
                        ownerData <= 1'b1;
                        busWe     <= arbBus.memory_i_we;
                        busAddr   <= arbBus.memory_i_addr;
                        busWdata  <= arbBus.memory_i_wdata;
                        busWstrb  <= arbBus.memory_i_wstrb;
                        busValid  <= 1'b1;
                        waitCnt   <= 8'd0;
                        // With fetch waiting, dataWins implies streak < max,
                        // so the increment saturates at the limit.
                        streak    <= arbBus.fetch_i_req ? streak + 3'd1 : 3'd0;
                        state     <= REQ;
                    end else if (arbBus.fetch_i_req) begin
                        ownerData <= 1'b0;
                        busWe     <= 1'b0;
                        busAddr   <= arbBus.fetch_i_addr;
                        busWdata  <= 32'd0;
                        busWstrb  <= 4'd0;
                        busValid  <= 1'b1;
                        waitCnt   <= 8'd0;
                        streak    <= 3'd0;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    if (arbBus.bus_i_ready || timedOut) begin
                        busValid <= 1'b0;
                        if (ownerData) begin
                            memDone  <= 1'b1;
                            memRdata <= busWe ? 32'd0 : respData;
                        end else begin
                            fetchDone  <= 1'b1;
                            fetchRdata <= respData;
                        end
                        if (!arbBus.bus_i_ready) begin
                            busErr  <= 1'b1;
                            errAddr <= busAddr;
                        end
                        state <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign arbBus.bus_o_valid       = busValid;
    assign arbBus.bus_o_we          = busWe;
    assign arbBus.bus_o_addr        = busAddr;
    assign arbBus.bus_o_wdata       = busWdata;
    assign arbBus.bus_o_wstrb       = busWstrb;
    assign arbBus.arb_o_fetch_rdata = fetchRdata;
    assign arbBus.arb_o_fetch_done  = fetchDone;
    assign arbBus.arb_o_mem_rdata   = memRdata;
    assign arbBus.arb_o_mem_done    = memDone;
    assign arbBus.arb_o_bus_err     = busErr;
    assign arbBus.arb_o_err_addr    = errAddr;
    assign arbBus.arb_o_fetch_stall = arbBus.fetch_i_req & ~fetchDone;
    assign arbBus.arb_o_mem_stall   = arbBus.memory_i_req & ~memDone;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (MAX_D_STREAK = 4, TIMEOUT = 8).
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge. "Cycle 0" is the cycle in which a request is first presented.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;

    mem_bus_arbiter_if busIf();

    mem_bus_arbiter #(
        .MAX_D_STREAK(4),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arbBus(busIf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idleInputs();
        busIf.fetch_i_req    = 1'b0;
        busIf.fetch_i_addr   = 32'd0;
        busIf.memory_i_req   = 1'b0;
        busIf.memory_i_we    = 1'b0;
        busIf.memory_i_addr  = 32'd0;
        busIf.memory_i_wdata = 32'd0;
        busIf.memory_i_wstrb = 4'd0;
        busIf.bus_i_ready    = 1'b0;
        busIf.bus_i_rdata    = 32'd0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b0;
        busIf.fetch_i_req = 1'b1;
        tick();
        tick();
        mid();
        nChecks++; if (busIf.bus_o_valid !== 1'b0) begin nFails++; $display("FAIL rst_valid: got %b expected 0", busIf.bus_o_valid); end
        nChecks++; if ({busIf.bus_o_we, busIf.bus_o_addr, busIf.bus_o_wdata, busIf.bus_o_wstrb} !== 69'd0) begin nFails++; $display("FAIL rst_bus_fields: got %h expected 0", {busIf.bus_o_we, busIf.bus_o_addr, busIf.bus_o_wdata, busIf.bus_o_wstrb}); end
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.arb_o_mem_done, busIf.arb_o_bus_err} !== 3'b000) begin nFails++; $display("FAIL rst_pulses: got %b expected 000", {busIf.arb_o_fetch_done, busIf.arb_o_mem_done, busIf.arb_o_bus_err}); end
        nChecks++; if ({busIf.arb_o_fetch_rdata, busIf.arb_o_mem_rdata, busIf.arb_o_err_addr} !== 96'd0) begin nFails++; $display("FAIL rst_data: got %h expected 0", {busIf.arb_o_fetch_rdata, busIf.arb_o_mem_rdata, busIf.arb_o_err_addr}); end
        nChecks++; if (busIf.arb_o_fetch_stall !== 1'b1) begin nFails++; $display("FAIL rst_fetch_stall: got %b expected 1", busIf.arb_o_fetch_stall); end
        nChecks++; if (busIf.arb_o_mem_stall !== 1'b0) begin nFails++; $display("FAIL rst_mem_stall: got %b expected 0", busIf.arb_o_mem_stall); end
        busIf.fetch_i_req = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_zero_wait_fetch();
        idleInputs();
        busIf.bus_i_ready  = 1'b1;
        busIf.bus_i_rdata  = 32'h0000_0013;
        busIf.fetch_i_req  = 1'b1;
        busIf.fetch_i_addr = 32'h8000_0000;
        mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.arb_o_fetch_stall} !== 2'b01) begin nFails++; $display("FAIL zw_c0 valid/stall: got %b expected 01", {busIf.bus_o_valid, busIf.arb_o_fetch_stall}); end
        tick(); mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.arb_o_fetch_stall, busIf.arb_o_fetch_done} !== 3'b110) begin nFails++; $display("FAIL zw_c1 valid/stall/done: got %b expected 110", {busIf.bus_o_valid, busIf.arb_o_fetch_stall, busIf.arb_o_fetch_done}); end
        nChecks++; if ({busIf.bus_o_addr, busIf.bus_o_we, busIf.bus_o_wstrb} !== {32'h8000_0000, 1'b0, 4'd0}) begin nFails++; $display("FAIL zw_c1 addr/we/wstrb: got %h expected %h", {busIf.bus_o_addr, busIf.bus_o_we, busIf.bus_o_wstrb}, {32'h8000_0000, 1'b0, 4'd0}); end
        tick(); mid();
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.arb_o_fetch_stall, busIf.bus_o_valid} !== 3'b100) begin nFails++; $display("FAIL zw_c2 done/stall/valid: got %b expected 100", {busIf.arb_o_fetch_done, busIf.arb_o_fetch_stall, busIf.bus_o_valid}); end
        nChecks++; if (busIf.arb_o_fetch_rdata !== 32'h0000_0013) begin nFails++; $display("FAIL zw_rdata: got %h expected 00000013", busIf.arb_o_fetch_rdata); end
        nChecks++; if (busIf.arb_o_mem_done !== 1'b0) begin nFails++; $display("FAIL zw_mem_done: got %b expected 0", busIf.arb_o_mem_done); end
        tick();
        busIf.fetch_i_req = 1'b0;
        mid();
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.bus_o_valid} !== 2'b00) begin nFails++; $display("FAIL zw_c3 done/valid: got %b expected 00", {busIf.arb_o_fetch_done, busIf.bus_o_valid}); end
        tick();
    endtask

    task automatic test_simultaneous();
        idleInputs();
        busIf.bus_i_ready   = 1'b1;
        busIf.bus_i_rdata   = 32'h1122_3344;
        busIf.memory_i_req  = 1'b1;
        busIf.memory_i_addr = 32'h0000_0100;
        busIf.fetch_i_req   = 1'b1;
        busIf.fetch_i_addr  = 32'h8000_0004;
        tick(); mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.bus_o_addr, busIf.bus_o_we} !== {1'b1, 32'h0000_0100, 1'b0}) begin nFails++; $display("FAIL sim_c1 data granted: got %h expected %h", {busIf.bus_o_valid, busIf.bus_o_addr, busIf.bus_o_we}, {1'b1, 32'h0000_0100, 1'b0}); end
        tick(); mid();
        nChecks++; if ({busIf.arb_o_mem_done, busIf.arb_o_fetch_done, busIf.arb_o_fetch_stall, busIf.arb_o_mem_stall} !== 4'b1010) begin nFails++; $display("FAIL sim_c2 done/stall: got %b expected 1010", {busIf.arb_o_mem_done, busIf.arb_o_fetch_done, busIf.arb_o_fetch_stall, busIf.arb_o_mem_stall}); end
        nChecks++; if (busIf.arb_o_mem_rdata !== 32'h1122_3344) begin nFails++; $display("FAIL sim_load_rdata: got %h expected 11223344", busIf.arb_o_mem_rdata); end
        tick();
        busIf.memory_i_req = 1'b0;
        busIf.bus_i_rdata  = 32'h0000_0093;
        mid();
        nChecks++; if (busIf.bus_o_valid !== 1'b0) begin nFails++; $display("FAIL sim_c3 valid: got %b expected 0", busIf.bus_o_valid); end
        tick(); mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.bus_o_addr} !== {1'b1, 32'h8000_0004}) begin nFails++; $display("FAIL sim_c4 fetch granted: got %h expected %h", {busIf.bus_o_valid, busIf.bus_o_addr}, {1'b1, 32'h8000_0004}); end
        tick(); mid();
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.arb_o_mem_done} !== 2'b10) begin nFails++; $display("FAIL sim_c5 done: got %b expected 10", {busIf.arb_o_fetch_done, busIf.arb_o_mem_done}); end
        nChecks++; if (busIf.arb_o_fetch_rdata !== 32'h0000_0093) begin nFails++; $display("FAIL sim_fetch_rdata: got %h expected 00000093", busIf.arb_o_fetch_rdata); end
        tick();
        busIf.fetch_i_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int   got;
        logic expData;
        idleInputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        got = 0;
        busIf.bus_i_ready   = 1'b1;
        busIf.bus_i_rdata   = 32'h0000_0077;
        busIf.memory_i_req  = 1'b1;
        busIf.memory_i_addr = 32'h0000_0200;
        busIf.fetch_i_req   = 1'b1;
        busIf.fetch_i_addr  = 32'h8000_0100;
        for (int c = 0; c < 40 && got < 10; c++) begin
            mid();
            if (busIf.arb_o_mem_done || busIf.arb_o_fetch_done) begin
                expData = ((got % 5) != 4);
                nChecks++; if ({busIf.arb_o_mem_done, busIf.arb_o_fetch_done} !== {expData, ~expData}) begin nFails++; $display("FAIL starve_grant%0d mem/fetch done: got %b expected %b", got, {busIf.arb_o_mem_done, busIf.arb_o_fetch_done}, {expData, ~expData}); end
                got++;
            end
            tick();
        end
        nChecks++; if (got !== 10) begin nFails++; $display("FAIL starve_count: got %0d completions expected 10", got); end
        busIf.memory_i_req = 1'b0;
        busIf.fetch_i_req  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_wait_store();
        logic [70:0] expBus;
        idleInputs();
        busIf.bus_i_rdata    = 32'h5555_5555;
        busIf.memory_i_req   = 1'b1;
        busIf.memory_i_we    = 1'b1;
        busIf.memory_i_addr  = 32'h0000_0300;
        busIf.memory_i_wdata = 32'hDEAD_BEEF;
        busIf.memory_i_wstrb = 4'b0011;
        expBus = {1'b1, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 4'b0011, 1'b0};
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 3) begin
                busIf.memory_i_addr  = 32'hFFFF_0000;
                busIf.memory_i_wdata = 32'd0;
                busIf.memory_i_wstrb = 4'hF;
            end
            if (c == 6) busIf.bus_i_ready = 1'b1;
            mid();
            nChecks++; if ({busIf.bus_o_valid, busIf.bus_o_we, busIf.bus_o_addr, busIf.bus_o_wdata, busIf.bus_o_wstrb, busIf.arb_o_mem_done} !== expBus) begin nFails++; $display("FAIL store_hold_c%0d: got %h expected %h", c, {busIf.bus_o_valid, busIf.bus_o_we, busIf.bus_o_addr, busIf.bus_o_wdata, busIf.bus_o_wstrb, busIf.arb_o_mem_done}, expBus); end
        end
        tick();
        busIf.bus_i_ready = 1'b0;
        mid();
        nChecks++; if ({busIf.arb_o_mem_done, busIf.bus_o_valid, busIf.arb_o_bus_err} !== 3'b100) begin nFails++; $display("FAIL store_c7 done/valid/err: got %b expected 100", {busIf.arb_o_mem_done, busIf.bus_o_valid, busIf.arb_o_bus_err}); end
        nChecks++; if (busIf.arb_o_mem_rdata !== 32'd0) begin nFails++; $display("FAIL store_rdata: got %h expected 00000000", busIf.arb_o_mem_rdata); end
        tick();
        busIf.memory_i_req = 1'b0;
        mid();
        nChecks++; if (busIf.arb_o_mem_done !== 1'b0) begin nFails++; $display("FAIL store_c8 done: got %b expected 0", busIf.arb_o_mem_done); end
        tick();
    endtask

    task automatic test_timeout();
        idleInputs();
        busIf.bus_i_rdata   = 32'hAAAA_AAAA;
        busIf.memory_i_req  = 1'b1;
        busIf.memory_i_addr = 32'h0000_2000;
        for (int c = 1; c <= 8; c++) begin
            tick(); mid();
            nChecks++; if ({busIf.bus_o_valid, busIf.arb_o_bus_err, busIf.arb_o_mem_done} !== 3'b100) begin nFails++; $display("FAIL tmo_c%0d valid/err/done: got %b expected 100", c, {busIf.bus_o_valid, busIf.arb_o_bus_err, busIf.arb_o_mem_done}); end
        end
        tick(); mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.arb_o_bus_err, busIf.arb_o_mem_done, busIf.arb_o_mem_stall} !== 4'b0110) begin nFails++; $display("FAIL tmo_c9 valid/err/done/stall: got %b expected 0110", {busIf.bus_o_valid, busIf.arb_o_bus_err, busIf.arb_o_mem_done, busIf.arb_o_mem_stall}); end
        nChecks++; if (busIf.arb_o_err_addr !== 32'h0000_2000) begin nFails++; $display("FAIL tmo_err_addr: got %h expected 00002000", busIf.arb_o_err_addr); end
        nChecks++; if (busIf.arb_o_mem_rdata !== 32'd0) begin nFails++; $display("FAIL tmo_rdata: got %h expected 00000000", busIf.arb_o_mem_rdata); end
        tick();
        busIf.memory_i_req = 1'b0;
        mid();
        nChecks++; if ({busIf.arb_o_bus_err, busIf.arb_o_mem_done} !== 2'b00) begin nFails++; $display("FAIL tmo_c10 err/done: got %b expected 00", {busIf.arb_o_bus_err, busIf.arb_o_mem_done}); end
        nChecks++; if (busIf.arb_o_err_addr !== 32'h0000_2000) begin nFails++; $display("FAIL tmo_err_addr_hold: got %h expected 00002000", busIf.arb_o_err_addr); end
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        idleInputs();
        busIf.fetch_i_req  = 1'b1;
        busIf.fetch_i_addr = 32'h8000_0200;
        tick(); mid();
        nChecks++; if (busIf.bus_o_valid !== 1'b1) begin nFails++; $display("FAIL rmid_c1 valid: got %b expected 1", busIf.bus_o_valid); end
        tick();
        #2;
        rst = 1'b0;
        #1;
        nChecks++; if ({busIf.bus_o_valid, busIf.bus_o_addr} !== 33'd0) begin nFails++; $display("FAIL rmid_async valid/addr: got %h expected 0", {busIf.bus_o_valid, busIf.bus_o_addr}); end
        mid();
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.arb_o_bus_err, busIf.arb_o_fetch_stall} !== 3'b001) begin nFails++; $display("FAIL rmid_in_reset done/err/stall: got %b expected 001", {busIf.arb_o_fetch_done, busIf.arb_o_bus_err, busIf.arb_o_fetch_stall}); end
        tick();
        busIf.fetch_i_addr = 32'h8000_0300;
        busIf.bus_i_ready  = 1'b1;
        busIf.bus_i_rdata  = 32'h0000_0517;
        rst = 1'b1;
        mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.arb_o_fetch_done} !== 2'b00) begin nFails++; $display("FAIL rmid_new_c0 valid/done: got %b expected 00", {busIf.bus_o_valid, busIf.arb_o_fetch_done}); end
        tick(); mid();
        nChecks++; if ({busIf.bus_o_valid, busIf.bus_o_addr, busIf.arb_o_fetch_done} !== {1'b1, 32'h8000_0300, 1'b0}) begin nFails++; $display("FAIL rmid_new_c1 valid/addr/done: got %h expected %h", {busIf.bus_o_valid, busIf.bus_o_addr, busIf.arb_o_fetch_done}, {1'b1, 32'h8000_0300, 1'b0}); end
        tick(); mid();
        nChecks++; if ({busIf.arb_o_fetch_done, busIf.arb_o_fetch_rdata} !== {1'b1, 32'h0000_0517}) begin nFails++; $display("FAIL rmid_new_c2 done/rdata: got %h expected %h", {busIf.arb_o_fetch_done, busIf.arb_o_fetch_rdata}, {1'b1, 32'h0000_0517}); end
        tick();
        busIf.fetch_i_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_simultaneous();
        test_starvation();
        test_wait_store();
        test_timeout();
        test_reset_mid_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL bench_time_limit: simulation still running at time %0t", $time);
        $fatal(1, "time limit");
    end
endmodule
